// File: rtl/audio_tx_pkg.sv
// Shared constants, types and helpers for the audio serial transmitter.
package audio_tx_pkg;

  // Register map
  localparam logic [3:0] AddrCtrl   = 4'd0;
  localparam logic [3:0] AddrDiv    = 4'd1;
  localparam logic [3:0] AddrLeft   = 4'd2;
  localparam logic [3:0] AddrRight  = 4'd3;
  localparam logic [3:0] AddrStatus = 4'd4;

  // CTRL bits
  localparam int unsigned CtrlEnable = 0;
  localparam int unsigned CtrlRepeat = 1;

  // STATUS bits ([3:0] is the FIFO level)
  localparam int unsigned StatusEmpty    = 4;
  localparam int unsigned StatusFull     = 5;
  localparam int unsigned StatusUnderrun = 6;
  localparam int unsigned StatusOverflow = 7;
  localparam int unsigned StatusRunning  = 8;

  localparam int unsigned FrameBits = 64;
  localparam int unsigned HalfBits  = 32;
  localparam int unsigned SampleW   = 16;

  typedef struct packed {
    logic [SampleW-1:0] left;
    logic [SampleW-1:0] right;
  } stereo_pair_t;

  typedef enum logic {StIdle, StRun} tx_state_e;

  // Serial bit for frame position idx: sample MSB-first in the top 16 bits of
  // each 32-bit half, zero padding below. 15-(idx%16) is just ~idx[3:0].
  function automatic logic frame_bit(stereo_pair_t p, logic [5:0] idx);
    logic [3:0] pos;
    logic       b;
    pos = ~idx[3:0];
    unique case (idx[5:4])
      2'b00:   b = p.left[pos];
      2'b10:   b = p.right[pos];
      default: b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/audio_tx_fifo.sv
// Synchronous FIFO with fall-through read data and simultaneous push/pop.
module audio_tx_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           rdata_o,
  output logic [$clog2(Depth+1)-1:0] level_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned LvlW  = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == LvlW'(Depth));
  assign level_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Occupancy follows the net effect of push and pop
  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers and level; contents are discarded on reset via the pointers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/audio_serial_tx.sv
// Master-mode left-justified stereo serial transmitter with host register bus.
module audio_serial_tx
  import audio_tx_pkg::*;
#(
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_W      = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [3:0]  Addr,
  input  logic [15:0] DataWr,
  output logic [15:0] DataRd,
  input  logic        En,
  input  logic        Rd,
  input  logic        Wr,
  output logic        TxBitClk,
  output logic        TxSync,
  output logic        TxSdo
);
  localparam int unsigned IdxW = $clog2(FrameBits);
  localparam int unsigned LvlW = $clog2(FIFO_DEPTH + 1);

  tx_state_e           state_q, state_d;
  logic [1:0]          ctrl_q, ctrl_d;
  logic [DIV_W-1:0]    div_q, div_d, cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] stage_q, stage_d;
  stereo_pair_t        last_q, last_d, pair_q, pair_d, load_pair, fifo_rdata;
  logic                uflow_q, uflow_d, oflow_q, oflow_d;
  logic [IdxW-1:0]     idx_q, idx_d, idx_inc;
  logic                bclk_q, bclk_d, sync_q, sync_d, sdo_q, sdo_d;
  logic                wr_en, push, load, fifo_pop, fifo_full, fifo_empty;
  logic [LvlW-1:0]     fifo_level;
  logic                unused_rd;

  // Reads have no side effects, so the strobe is not needed
  assign unused_rd = Rd;

  assign wr_en    = En & Wr;
  assign push     = wr_en & (Addr == AddrRight);
  assign fifo_pop = load & ~fifo_empty;
  assign idx_inc  = idx_q + 1'b1;

  // On underrun, either replay the last pair or send silence
  assign load_pair = !fifo_empty ? fifo_rdata
                   : (ctrl_q[CtrlRepeat] ? last_q : '0);

  audio_tx_fifo #(
    .Width ($bits(stereo_pair_t)),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (Clk),
    .rst_ni  (Reset),
    .push_i  (push),
    .wdata_i (stereo_pair_t'({stage_q, DataWr})),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Host register writes and sticky flags (a set in the same cycle wins over a clear)
  always_comb begin
    ctrl_d  = ctrl_q;
    div_d   = div_q;
    stage_d = stage_q;
    uflow_d = uflow_q;
    oflow_d = oflow_q;
    last_d  = last_q;
    if (wr_en) begin
      unique case (Addr)
        AddrCtrl:   ctrl_d  = DataWr[1:0];
        AddrDiv:    div_d   = DataWr[DIV_W-1:0];
        AddrLeft:   stage_d = DataWr[SAMPLE_W-1:0];
        AddrStatus: begin
          if (DataWr[StatusUnderrun]) uflow_d = 1'b0;
          if (DataWr[StatusOverflow]) oflow_d = 1'b0;
        end
        default: ;
      endcase
    end
    if (push && fifo_full && !fifo_pop) oflow_d = 1'b1;
    if (load && fifo_empty)             uflow_d = 1'b1;
    if (fifo_pop)                       last_d  = fifo_rdata;
  end

  // Sequencer: bit-clock divider, bit index, frame loads and serial outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bclk_d  = bclk_q;
    idx_d   = idx_q;
    pair_d  = pair_q;
    sync_d  = sync_q;
    sdo_d   = sdo_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d  = '0;
        idx_d  = '0;
        bclk_d = 1'b0;
        sync_d = 1'b0;
        sdo_d  = 1'b0;
        if (ctrl_q[CtrlEnable]) begin
          load    = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        // >= so that lowering DIV below the running count wraps at once
        if (cnt_q >= div_q) begin
          cnt_d  = '0;
          bclk_d = ~bclk_q;
          if (bclk_q) begin
            if (idx_q == IdxW'(FrameBits - 1)) begin
              idx_d = '0;
              if (ctrl_q[CtrlEnable]) begin
                load = 1'b1;
              end else begin
                state_d = StIdle;
                sync_d  = 1'b0;
                sdo_d   = 1'b0;
              end
            end else begin
              idx_d  = idx_inc;
              sync_d = (idx_inc >= IdxW'(HalfBits));
              sdo_d  = frame_bit(pair_q, idx_inc);
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (load) begin
      pair_d = load_pair;
      idx_d  = '0;
      sync_d = 1'b0;
      sdo_d  = frame_bit(load_pair, '0);
    end
  end

  // State registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
      ctrl_q  <= '0;
      div_q   <= '0;
      stage_q <= '0;
      last_q  <= '0;
      pair_q  <= '0;
      uflow_q <= 1'b0;
      oflow_q <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      bclk_q  <= 1'b0;
      sync_q  <= 1'b0;
      sdo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      div_q   <= div_d;
      stage_q <= stage_d;
      last_q  <= last_d;
      pair_q  <= pair_d;
      uflow_q <= uflow_d;
      oflow_q <= oflow_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      bclk_q  <= bclk_d;
      sync_q  <= sync_d;
      sdo_q   <= sdo_d;
    end
  end

  assign TxBitClk = bclk_q;
  assign TxSync   = sync_q;
  assign TxSdo    = sdo_q;

  // Combinational register read-back
  always_comb begin
    DataRd = '0;
    unique case (Addr)
      AddrCtrl: DataRd = 16'(ctrl_q);
      AddrDiv:  DataRd = 16'(div_q);
      AddrStatus: begin
        DataRd[3:0]            = 4'(fifo_level);
        DataRd[StatusEmpty]    = fifo_empty;
        DataRd[StatusFull]     = fifo_full;
        DataRd[StatusUnderrun] = uflow_q;
        DataRd[StatusOverflow] = oflow_q;
        DataRd[StatusRunning]  = (state_q == StRun);
      end
      default: DataRd = '0;
    endcase
  end

endmodule
